// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0), MSB first, one word per accepted start.
// sck, csn and mosi are all driven straight from flops; miso is captured on the
// clk edge that raises sck. After each word csn is held high for a guard interval
// (busy still asserted) so the slave always sees a clean deselect.
module spi_master #(
    parameter int unsigned BITS    = 8,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BITS-1:0] data_to_slave,
    output logic [BITS-1:0] data_from_slave,
    output logic            busy,
    output logic            ready,
    output logic            sck,
    output logic            mosi,
    input  logic            miso,
    output logic            csn
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned EW = $clog2(2 * BITS + 1);

    localparam logic [DW-1:0] DivLast  = DW'(CLK_DIV - 1);
    // sck edge count just before the final falling edge
    localparam logic [EW-1:0] LastFall = EW'(2 * BITS - 1);
    // HOLD spans two half-periods; the count runs on past 2*BITS to time it
    localparam logic [EW-1:0] HoldEnd  = EW'(2 * BITS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_t;

    state_t          state;
    logic [DW-1:0]   div_cnt;
    logic [EW-1:0]   edge_cnt;
    logic [BITS-1:0] tx;
    logic [BITS-1:0] rx;
    logic            period_end;

    // Last clk cycle of the current sck half-period
    assign period_end = (div_cnt == DivLast);

    // Transfer sequencer; every output is a flop updated here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= StIdle;
            div_cnt         <= '0;
            edge_cnt        <= '0;
            tx              <= '0;
            rx              <= '0;
            data_from_slave <= '0;
            busy            <= 1'b0;
            ready           <= 1'b0;
            sck             <= 1'b0;
            mosi            <= 1'b0;
            csn             <= 1'b1;
        end else begin
            ready <= 1'b0;

            // Half-period timer free-runs whenever a transfer is in flight
            if (state != StIdle) begin
                div_cnt <= period_end ? '0 : div_cnt + 1'b1;
            end

            case (state)
                StIdle: begin
                    if (start) begin
                        tx       <= data_to_slave;
                        mosi     <= data_to_slave[BITS-1];
                        csn      <= 1'b0;
                        busy     <= 1'b1;
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                        state    <= StSetup;
                    end
                end

                StSetup: begin
                    if (period_end) begin
                        sck      <= 1'b1;
                        rx       <= {rx[BITS-2:0], miso};
                        edge_cnt <= EW'(1);
                        state    <= StShift;
                    end
                end

                StShift: begin
                    if (period_end) begin
                        edge_cnt <= edge_cnt + 1'b1;
                        if (sck) begin
                            sck <= 1'b0;
                            tx  <= tx << 1;
                            if (edge_cnt == LastFall) begin
                                mosi  <= 1'b0;
                                state <= StHold;
                            end else begin
                                mosi <= tx[BITS-2];
                            end
                        end else begin
                            sck <= 1'b1;
                            rx  <= {rx[BITS-2:0], miso};
                        end
                    end
                end

                StHold: begin
                    if (period_end) begin
                        if (edge_cnt == HoldEnd) begin
                            csn             <= 1'b1;
                            data_from_slave <= rx;
                            ready           <= 1'b1;
                            edge_cnt        <= '0;
                            state           <= StGap;
                        end else begin
                            edge_cnt <= edge_cnt + 1'b1;
                        end
                    end
                end

                StGap: begin
                    if (period_end) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: an 8-bit/div-4 instance (loopback or behavioural slave on
// miso) and a 16-bit/div-2 instance with miso tied high. A timeline model predicts
// every output from the cycle offset since acceptance; directed checks pin it.
module tb_spi_master;

    logic clk;
    logic rst;

    logic        start8, busy8, ready8, sck8, mosi8, miso8, csn8;
    logic [7:0]  d8, dfs8;
    logic        start16, busy16, ready16, sck16, mosi16, miso16, csn16;
    logic [15:0] d16, dfs16;

    logic        slave_mode;
    logic        sl_miso;
    logic [7:0]  sl_tx, sl_rx;

    int n_cmp = 0;
    int n_bad = 0;

    spi_master #(.BITS(8), .CLK_DIV(4)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .data_to_slave(d8),
        .data_from_slave(dfs8), .busy(busy8), .ready(ready8), .sck(sck8),
        .mosi(mosi8), .miso(miso8), .csn(csn8)
    );

    spi_master #(.BITS(16), .CLK_DIV(2)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .data_to_slave(d16),
        .data_from_slave(dfs16), .busy(busy16), .ready(ready16), .sck(sck16),
        .mosi(mosi16), .miso(miso16), .csn(csn16)
    );

    assign miso8  = slave_mode ? sl_miso : mosi8;
    assign miso16 = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected {csn, sck, mosi, busy, ready} at offset t after the accepting edge
    function automatic logic [4:0] expv(int b, int d, bit act, int t, logic [15:0] w);
        logic c, s, m, r;
        int f;
        if (!act) return 5'b10000;
        c = (t >= (2 * b + 2) * d);
        s = (t < 2 * b * d) && (((t / d) % 2) == 1);
        f = t / (2 * d);
        m = (f < b) ? w[b-1-f] : 1'b0;
        r = (t == (2 * b + 2) * d);
        return {c, s, m, 1'b1, r};
    endfunction

    // Behavioural mode-0 slave preloaded with 8'h3C
    always @(negedge csn8) begin
        sl_tx   = 8'h3C;
        sl_miso = sl_tx[7];
    end
    always @(posedge sck8) sl_rx = {sl_rx[6:0], mosi8};
    always @(negedge sck8) begin
        sl_tx   = sl_tx << 1;
        sl_miso = sl_tx[7];
    end

    // Timeline models: offset since acceptance, latched word, expected result
    bit          m8_act = 1'b0, m16_act = 1'b0;
    int          m8_t = 0, m16_t = 0;
    logic [15:0] m8_w = '0, m16_w = '0;
    logic [7:0]  m8_rx = '0, m8_dfs = '0;
    logic [15:0] m16_dfs = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m8_act = 1'b0;
            m8_dfs = '0;
        end else if (m8_act) begin
            m8_t++;
            if (m8_t == 72) m8_dfs = m8_rx;
            if (m8_t == 76) m8_act = 1'b0;
        end else if (start8) begin
            m8_act = 1'b1;
            m8_t   = 0;
            m8_w   = {8'h00, d8};
            m8_rx  = slave_mode ? 8'h3C : d8;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m16_act = 1'b0;
            m16_dfs = '0;
        end else if (m16_act) begin
            m16_t++;
            if (m16_t == 68) m16_dfs = 16'hFFFF;
            if (m16_t == 70) m16_act = 1'b0;
        end else if (start16) begin
            m16_act = 1'b1;
            m16_t   = 0;
            m16_w   = d16;
        end
    end

    // Per-cycle comparison against the models, away from the active edge
    always @(negedge clk) begin
        cmp("outs8", {27'd0, csn8, sck8, mosi8, busy8, ready8}, {27'd0, expv(8, 4, m8_act, m8_t, m8_w)});
        cmp("dfs8", {24'd0, dfs8}, {24'd0, m8_dfs});
        cmp("outs16", {27'd0, csn16, sck16, mosi16, busy16, ready16},
            {27'd0, expv(16, 2, m16_act, m16_t, m16_w)});
        cmp("dfs16", {16'd0, dfs16}, {16'd0, m16_dfs});
    end

    // One 8-bit transfer, observed for 80 cycles; optional reset at offset rst_at
    task automatic xfer8(input logic [7:0] w, input int rst_at, output int rdy_at, output int nrdy);
        rdy_at = -1;
        nrdy   = 0;
        @(negedge clk);
        d8     = w;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            if (k == rst_at) begin
                #1;
                cmp("pre_rst_sck_high", {31'd0, sck8}, 32'd1);
                rst = 1'b1;
                #1;
                cmp("rst_async_csn", {31'd0, csn8}, 32'd1);
                cmp("rst_async_sck", {31'd0, sck8}, 32'd0);
                cmp("rst_async_busy", {31'd0, busy8}, 32'd0);
                cmp("rst_async_dfs", {24'd0, dfs8}, 32'd0);
            end
            @(negedge clk);
            rst = 1'b0;
            if (ready8) begin
                nrdy++;
                if (rdy_at < 0) rdy_at = k;
            end
        end
    endtask

    initial begin
        int   rdy_at, nrdy, r1, r2, rises, csn_rise, busy_fall, sck_csn_bad;
        logic [7:0] rbits;
        logic sck_prev;

        start8 = 1'b0; d8 = '0; start16 = 1'b0; d16 = '0;
        slave_mode = 1'b0; rst = 1'b0;
        sl_tx = '0; sl_rx = '0; sl_miso = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        cmp("reset_csn", {31'd0, csn8}, 32'd1);
        cmp("reset_sck", {31'd0, sck8}, 32'd0);
        cmp("reset_mosi", {31'd0, mosi8}, 32'd0);
        cmp("reset_busy", {31'd0, busy8}, 32'd0);
        cmp("reset_ready", {31'd0, ready8}, 32'd0);
        cmp("reset_dfs", {24'd0, dfs8}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Loopback A5 with ignored starts at edges 10 and 72, then restart once idle
        d8 = 8'hA5;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cmp("accept_csn_low", {31'd0, csn8}, 32'd0);
        cmp("accept_busy", {31'd0, busy8}, 32'd1);
        cmp("accept_mosi_msb", {31'd0, mosi8}, 32'd1);
        nrdy = 0; r1 = -1; r2 = -1; rises = 0; rbits = '0; sck_prev = 1'b0;
        csn_rise = -1; busy_fall = -1; sck_csn_bad = 0;
        for (int k = 1; k <= 160; k++) begin
            @(negedge clk);
            if (k == 1) d8 = 8'h5A;
            if (ready8) begin
                nrdy++;
                if (nrdy == 1) begin
                    r1 = k;
                    cmp("loop_dfs_a5", {24'd0, dfs8}, 32'hA5);
                end else if (nrdy == 2) begin
                    r2 = k;
                    cmp("loop_dfs_5a", {24'd0, dfs8}, 32'h5A);
                end
            end
            if (k <= 76 && sck8 && !sck_prev) begin
                rises++;
                rbits = {rbits[6:0], mosi8};
            end
            sck_prev = sck8;
            if (csn8 && sck8) sck_csn_bad++;
            if (csn_rise < 0 && csn8) csn_rise = k;
            if (busy_fall < 0 && !busy8) busy_fall = k;
            if (k == 77) cmp("restart_busy", {31'd0, busy8}, 32'd1);
            start8 = (k == 9 || k == 71 || k == 76);
        end
        cmp("ready_cycle", r1, 72);
        cmp("ready_count", nrdy, 2);
        cmp("restart_ready_cycle", r2, 149);
        cmp("sck_rises", rises, 8);
        cmp("mosi_at_rises", {24'd0, rbits}, 32'hA5);
        cmp("csn_low_interior_edges", csn_rise - 1, 71);
        cmp("busy_fall_cycle", busy_fall, 76);
        cmp("sck_high_while_csn_high", sck_csn_bad, 0);

        // Reset in the middle of a transfer, then a clean transfer from idle
        xfer8(8'h3F, 30, rdy_at, nrdy);
        cmp("aborted_ready_count", nrdy, 0);
        xfer8(8'h96, 0, rdy_at, nrdy);
        cmp("post_rst_ready_cycle", rdy_at, 72);
        cmp("post_rst_dfs", {24'd0, dfs8}, 32'h96);

        // Exchange with the behavioural slave
        slave_mode = 1'b1;
        xfer8(8'hC3, 0, rdy_at, nrdy);
        cmp("slave_ready_cycle", rdy_at, 72);
        cmp("master_reads", {24'd0, dfs8}, 32'h3C);
        cmp("slave_captures", {24'd0, sl_rx}, 32'hC3);
        slave_mode = 1'b0;

        // 16-bit, div-2, miso tied high
        @(negedge clk);
        d16 = 16'h1234;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        rdy_at = -1; nrdy = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (ready16) begin
                nrdy++;
                if (rdy_at < 0) rdy_at = k;
            end
        end
        cmp("w16_ready_cycle", rdy_at, 68);
        cmp("w16_ready_count", nrdy, 1);
        cmp("w16_dfs", {16'd0, dfs16}, 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
